// File: rtl/pcie_msi_ctrl.sv
// MSI request scheduler for the PCIe bridge.
// Captures interrupt rising edges as sticky pending bits and issues them round-robin.
module pcie_msi_ctrl #(
  parameter int N_IRQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             user_link_up,
  input  logic             msi_enable,
  input  logic [2:0]       msi_vector_width,
  output logic             intx_msi_request,
  input  logic             intx_msi_grant,
  output logic [4:0]       msi_vector_num,
  output logic [N_IRQ-1:0] pending,
  output logic             busy,
  output logic             timeout_err
);

  localparam int SW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] clr;
  logic [SW-1:0]    sel_q, sel_d;
  logic [SW-1:0]    rr_q, rr_d;
  logic [SW-1:0]    pick;
  logic [SW-1:0]    nxt;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       vec_q, vec_d;
  logic [4:0]       vmask;
  logic [2:0]       wc;
  logic             tmo_q, tmo_d;
  logic             allow_q;
  logic             found;
  int               j;

  assign elig = pend_q & ~irq_mask;
  assign nxt  = (sel_q == SW'(N_IRQ - 1)) ? '0 : sel_q + SW'(1);
  assign wc   = (msi_vector_width > 3'd5) ? 3'd5 : msi_vector_width;
  assign vmask = 5'((6'd1 << wc) - 6'd1);

  // First eligible source at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    j     = 0;
    for (int i = 0; i < N_IRQ; i++) begin
      j = int'(rr_q) + i;
      if (j >= N_IRQ) j = j - N_IRQ;
      if (!found && elig[j]) begin
        found = 1'b1;
        pick  = SW'(j);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      irq_q   <= '0;
      pend_q  <= '0;
      sel_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      tmo_q   <= 1'b0;
      allow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_in;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      tmo_q   <= tmo_d;
      allow_q <= user_link_up & msi_enable;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    tmo_d   = 1'b0;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (allow_q && |elig) begin
          sel_d   = pick;
          vec_d   = 5'(pick) & vmask;
          cnt_d   = '0;
          state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        cnt_d = cnt_q + CW'(1);
        if (intx_msi_grant) begin
          clr[sel_q] = 1'b1;
          rr_d       = nxt;
          state_d    = GAP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          rr_d    = nxt;
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge on the granted source wins over its clear.
    pend_d = (pend_q & ~clr) | (irq_in & ~irq_q);
  end

  always_comb begin
    intx_msi_request = (state_q == WAIT_GNT);
    busy             = (state_q == WAIT_GNT);
  end

  assign msi_vector_num = vec_q;
  assign pending        = pend_q;
  assign timeout_err    = tmo_q;

endmodule

// File: tb/tb_pcie_msi_ctrl.sv
// Directed bench for pcie_msi_ctrl (N_IRQ=4, TIMEOUT=8).
module tb_pcie_msi_ctrl;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [3:0] irq_in;
  logic [3:0] irq_mask;
  logic       user_link_up;
  logic       msi_enable;
  logic [2:0] msi_vector_width;
  logic       intx_msi_request;
  logic       intx_msi_grant;
  logic [4:0] msi_vector_num;
  logic [3:0] pending;
  logic       busy;
  logic       timeout_err;

  int n_chk  = 0;
  int n_fail = 0;
  logic [3:0] exp_p;

  always #5 aclk = ~aclk;

  pcie_msi_ctrl #(.N_IRQ(4), .TIMEOUT(8)) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .irq_in           (irq_in),
    .irq_mask         (irq_mask),
    .user_link_up     (user_link_up),
    .msi_enable       (msi_enable),
    .msi_vector_width (msi_vector_width),
    .intx_msi_request (intx_msi_request),
    .intx_msi_grant   (intx_msi_grant),
    .msi_vector_num   (msi_vector_num),
    .pending          (pending),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (2) tick();
    aresetn = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    aresetn = 1'b0;
    irq_in = '0;
    irq_mask = '0;
    user_link_up = 1'b1;
    msi_enable = 1'b1;
    msi_vector_width = 3'd2;
    intx_msi_grant = 1'b0;
    #2;
    chk("rst_req", intx_msi_request, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vec", msi_vector_num, 0);
    chk("rst_pend", pending, 0);
    chk("rst_tmo", timeout_err, 0);
    do_reset();

    // single source, grant 3 cycles after request
    irq_in = 4'b0100;
    tick();
    chk("s_pend", pending, 4'h4);
    chk("s_noreq", intx_msi_request, 0);
    irq_in = '0;
    tick();
    chk("s_req", intx_msi_request, 1);
    chk("s_busy", busy, 1);
    chk("s_vec", msi_vector_num, 2);
    tick();
    chk("s_hold1", intx_msi_request, 1);
    tick();
    chk("s_hold2", intx_msi_request, 1);
    tick();
    chk("s_hold3", intx_msi_request, 1);
    chk("s_vhold", msi_vector_num, 2);
    intx_msi_grant = 1'b1;
    tick();
    intx_msi_grant = 1'b0;
    chk("s_drop", intx_msi_request, 0);
    chk("s_bdrop", busy, 0);
    chk("s_clr", pending, 0);
    chk("s_tmo", timeout_err, 0);
    tick();
    chk("s_idle", intx_msi_request, 0);
    chk("s_vlast", msi_vector_num, 2);

    // round robin from pointer 0
    do_reset();
    irq_in = 4'hF;
    tick();
    chk("rr_pend", pending, 4'hF);
    irq_in = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_req%0d", k), intx_msi_request, 1);
      chk($sformatf("rr_vec%0d", k), msi_vector_num, k);
      tick();
      intx_msi_grant = 1'b1;
      tick();
      intx_msi_grant = 1'b0;
      exp_p = 4'(4'hF << (k + 1));
      chk($sformatf("rr_gap%0d", k), intx_msi_request, 0);
      chk($sformatf("rr_pclr%0d", k), pending, exp_p);
      tick();
      chk($sformatf("rr_idle%0d", k), intx_msi_request, 0);
      tick();
    end
    chk("rr_done", intx_msi_request, 0);
    irq_in = 4'b1010;
    tick();
    irq_in = '0;
    tick();
    chk("rr_w1", msi_vector_num, 1);
    chk("rr_w1r", intx_msi_request, 1);
    tick();
    intx_msi_grant = 1'b1;
    tick();
    intx_msi_grant = 1'b0;
    tick();
    tick();
    chk("rr_w3", msi_vector_num, 3);
    chk("rr_w3r", intx_msi_request, 1);
    tick();
    intx_msi_grant = 1'b1;
    tick();
    intx_msi_grant = 1'b0;
    chk("rr_wpend", pending, 0);
    tick();

    // vector folding
    msi_vector_width = 3'd1;
    irq_in = 4'b1000;
    tick();
    irq_in = '0;
    tick();
    chk("fold_req", intx_msi_request, 1);
    chk("fold_vec", msi_vector_num, 1);
    intx_msi_grant = 1'b1;
    tick();
    intx_msi_grant = 1'b0;
    tick();
    msi_vector_width = 3'd2;

    // timeout, pointer at 0
    irq_in = 4'b0010;
    tick();
    irq_in = '0;
    tick();
    chk("to_req0", intx_msi_request, 1);
    chk("to_vec", msi_vector_num, 1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("to_hold%0d", i), intx_msi_request, 1);
      chk($sformatf("to_notmo%0d", i), timeout_err, 0);
    end
    tick();
    chk("to_drop", intx_msi_request, 0);
    chk("to_pulse", timeout_err, 1);
    chk("to_pend", pending, 4'h2);
    tick();
    chk("to_once", timeout_err, 0);
    chk("to_idle", intx_msi_request, 0);
    tick();
    chk("to_retry", intx_msi_request, 1);
    chk("to_rvec", msi_vector_num, 1);
    intx_msi_grant = 1'b1;
    tick();
    intx_msi_grant = 1'b0;
    chk("to_clr", pending, 0);
    chk("to_okgnt", timeout_err, 0);
    tick();

    // msi_enable gating
    msi_enable = 1'b0;
    irq_in = 4'b0001;
    tick();
    irq_in = '0;
    chk("en_pend", pending, 4'h1);
    tick();
    chk("en_noreq0", intx_msi_request, 0);
    tick();
    chk("en_noreq1", intx_msi_request, 0);
    msi_enable = 1'b1;
    tick();
    chk("en_lat1", intx_msi_request, 0);
    tick();
    chk("en_lat2", intx_msi_request, 1);
    chk("en_vec", msi_vector_num, 0);
    intx_msi_grant = 1'b1;
    tick();
    intx_msi_grant = 1'b0;
    tick();

    // mask holds a pending source back
    irq_mask = 4'b0100;
    irq_in = 4'b0100;
    tick();
    irq_in = '0;
    chk("m_pend", pending, 4'h4);
    tick();
    chk("m_noreq0", intx_msi_request, 0);
    tick();
    chk("m_noreq1", intx_msi_request, 0);
    chk("m_keep", pending, 4'h4);
    irq_mask = '0;
    tick();
    chk("m_req", intx_msi_request, 1);
    chk("m_vec", msi_vector_num, 2);
    intx_msi_grant = 1'b1;
    tick();
    intx_msi_grant = 1'b0;
    chk("m_clr", pending, 0);
    tick();

    // new edge on granted source during grant
    irq_in = 4'b0001;
    tick();
    irq_in = '0;
    tick();
    chk("eg_req", intx_msi_request, 1);
    chk("eg_vec", msi_vector_num, 0);
    intx_msi_grant = 1'b1;
    irq_in = 4'b0001;
    tick();
    intx_msi_grant = 1'b0;
    irq_in = '0;
    chk("eg_keep", pending, 4'h1);
    chk("eg_gap", intx_msi_request, 0);
    tick();
    tick();
    chk("eg_resend", intx_msi_request, 1);
    chk("eg_rvec", msi_vector_num, 0);
    intx_msi_grant = 1'b1;
    tick();
    intx_msi_grant = 1'b0;
    chk("eg_clr", pending, 0);
    tick();

    // asynchronous reset during WAIT_GNT
    irq_in = 4'b0010;
    tick();
    irq_in = '0;
    tick();
    chk("ar_req", intx_msi_request, 1);
    tick();
    tick();
    #3;
    aresetn = 1'b0;
    #1;
    chk("ar_async", intx_msi_request, 0);
    chk("ar_busy", busy, 0);
    chk("ar_pend", pending, 0);
    chk("ar_vec", msi_vector_num, 0);
    repeat (10) tick();
    chk("ar_tmo", timeout_err, 0);
    aresetn = 1'b1;
    repeat (3) tick();
    chk("ar_after", intx_msi_request, 0);
    chk("ar_tmo2", timeout_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
